// File: rtl/key_expansion_inv.sv
// key_expansion_inv: reverse AES-128 key schedule that streams round keys 10..0 over valid/ready
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   load request, honoured only while idle
//   last_key   in   round-10 key, sampled with start
//   key_out    out  current round key (InvMixColumns applied to rounds 9..1 when EQ_INV)
//   key_round  out  round index of key_out
//   key_valid  out  key_out/key_round offered to the consumer
//   key_ready  in   consumer accepts key_out
//   busy       out  stream in progress
//   done       out  one-cycle pulse after the round-0 transfer
module key_expansion_inv #(
    parameter bit EQ_INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t       state_q;
    logic [127:0] kreg_q;
    logic [127:0] kreg_d;
    logic [3:0]   rnd_q;
    logic         done_q;
    logic [31:0]  p0, p1, p2, p3;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 1; i < 10; i++)
            c = (i < int'(r)) ? xt(c) : c;
        return c;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // one backward schedule step: undo the word chaining, then recover w0 through the g() function
    assign p3 = kreg_q[31:0] ^ kreg_q[63:32];
    assign p2 = kreg_q[63:32] ^ kreg_q[95:64];
    assign p1 = kreg_q[95:64] ^ kreg_q[127:96];
    assign p0 = kreg_q[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(rnd_q), 24'h0};
    assign kreg_d = {p0, p1, p2, p3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kreg_q  <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    kreg_q  <= last_key;
                    rnd_q   <= 4'd10;
                    state_q <= EMIT;
                end
            end else if (key_ready) begin
                if (rnd_q == 4'd0) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    kreg_q <= kreg_d;
                    rnd_q  <= rnd_q - 4'd1;
                end
            end
        end
    end

    assign key_out   = (EQ_INV && rnd_q >= 4'd1 && rnd_q <= 4'd9) ?
                       {inv_mix_col(kreg_q[127:96]), inv_mix_col(kreg_q[95:64]),
                        inv_mix_col(kreg_q[63:32]), inv_mix_col(kreg_q[31:0])} : kreg_q;
    assign key_round = rnd_q;
    assign key_valid = state_q == EMIT;
    assign busy      = state_q == EMIT;
    assign done      = done_q;
endmodule

// File: tb/tb_key_expansion_inv.sv
// tb_key_expansion_inv: randomized check of the reverse key schedule against a forward-expansion model
module tb_key_expansion_inv;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         key_ready = 1'b0;
    logic [127:0] last_key = '0;
    logic [127:0] ko0, ko1;
    logic [3:0]   kr0, kr1;
    logic         kv0, kv1, b0, b1, d0, d1;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [7:0]   rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] rk [11];
    logic [127:0] obs0 [11];
    logic [127:0] obs1 [11];
    logic [127:0] fips_k0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_expansion_inv #(.EQ_INV(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
        .key_out(ko0), .key_round(kr0), .key_valid(kv0), .key_ready(key_ready),
        .busy(b0), .done(d0));

    key_expansion_inv #(.EQ_INV(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
        .key_out(ko1), .key_round(kr1), .key_valid(kv1), .key_ready(key_ready),
        .busy(b1), .done(d1));

    always #5 clk = ~clk;

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box table generated by walking the multiplicative group with generator 3
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    // forward AES-128 expansion from K0; the DUT must reproduce it backwards from K10
    task automatic build_keys(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon_t[i / 4 - 1], 24'h0};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix_ref(input logic [127:0] k);
        logic [7:0]   c [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] o;
        c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09;
        o = '0;
        for (int col = 0; col < 4; col++) begin
            for (int j = 0; j < 4; j++) a[j] = k[127 - 32 * col - 8 * j -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 0;
                for (int j = 0; j < 4; j++) b = b ^ gm(c[(j - row + 4) % 4], a[j]);
                o[127 - 32 * col - 8 * row -: 8] = b;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] exp_eq(input int r);
        return (r >= 1 && r <= 9) ? inv_mix_ref(rk[r]) : rk[r];
    endfunction

    task automatic load(input logic [127:0] k);
        @(negedge clk);
        start = 1'b1;
        last_key = k;
        @(negedge clk);
        start = 1'b0;
        last_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic consume(input bit rnd_rdy, input bit poke, input bit chain);
        int r = 10;
        int cyc = 0;
        bit rdy;
        while (r >= 0 && cyc < 400) begin
            checks++; if (kv0 !== 1'b1) begin errors++; $display("FAIL valid r=%0d got %b exp 1", r, kv0); end
            checks++; if (kr0 !== 4'(r)) begin errors++; $display("FAIL round got %0d exp %0d", kr0, r); end
            checks++; if (ko0 !== rk[r]) begin errors++; $display("FAIL key r=%0d got %h exp %h", r, ko0, rk[r]); end
            checks++; if (ko1 !== exp_eq(r)) begin errors++; $display("FAIL eqkey r=%0d got %h exp %h", r, ko1, exp_eq(r)); end
            checks++; if (b0 !== 1'b1 || d0 !== 1'b0) begin errors++; $display("FAIL busy/done r=%0d got %b/%b exp 1/0", r, b0, d0); end
            obs0[r] = ko0;
            obs1[r] = ko1;
            rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            key_ready = rdy;
            start = poke && r == 6;
            if (start) last_key = '1;
            @(negedge clk);
            cyc++;
            if (rdy) r--;
        end
        start = 1'b0;
        checks++; if (r >= 0) begin errors++; $display("FAIL timeout stuck at round %0d exp -1", r); end
        checks++; if (d0 !== 1'b1 || b0 !== 1'b0 || kv0 !== 1'b0) begin errors++; $display("FAIL end done/busy/valid got %b/%b/%b exp 1/0/0", d0, b0, kv0); end
        if (!rnd_rdy) begin
            checks++; if (cyc != 11) begin errors++; $display("FAIL cycles got %0d exp 11", cyc); end
        end
        if (chain) begin
            start = 1'b1;
            last_key = rk[10];
            @(negedge clk);
            start = 1'b0;
            last_key = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            key_ready = 1'b0;
            @(negedge clk);
            checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL done pulse width got %b exp 0", d0); end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++; if ({ko0, kr0, kv0, b0, d0} !== '0) begin errors++; $display("FAIL reset got %h/%0d/%b/%b/%b exp 0", ko0, kr0, kv0, b0, d0); end
        checks++; if ({ko1, kr1, kv1, b1, d1} !== '0) begin errors++; $display("FAIL reset_eq got %h/%0d exp 0", ko1, kr1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ready;
        key_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (kv0 !== 1'b0 || b0 !== 1'b0 || kr0 !== 4'd0) begin errors++; $display("FAIL idle got v%b b%b r%0d exp 0", kv0, b0, kr0); end
        end
        key_ready = 1'b0;
    endtask

    task automatic test_fips;
        build_keys(fips_k0);
        load(rk[10]);
        consume(1'b0, 1'b0, 1'b0);
        checks++; if (obs0[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL fips10 got %h", obs0[10]); end
        checks++; if (obs0[9] !== 128'hac7766f319fadc2128d12941575c006e) begin errors++; $display("FAIL fips9 got %h", obs0[9]); end
        checks++; if (obs0[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL fips1 got %h", obs0[1]); end
        checks++; if (obs0[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL fips0 got %h", obs0[0]); end
    endtask

    task automatic test_eq_inv;
        checks++; if (obs1[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL eq10 got %h", obs1[10]); end
        checks++; if (obs1[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL eq0 got %h", obs1[0]); end
        checks++; if (obs1[5] !== inv_mix_ref(rk[5])) begin errors++; $display("FAIL eq5 got %h exp %h", obs1[5], inv_mix_ref(rk[5])); end
    endtask

    task automatic test_backpressure;
        build_keys(fips_k0);
        load(rk[10]);
        consume(1'b1, 1'b0, 1'b0);
        checks++; if (obs0[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL bp0 got %h", obs0[0]); end
    endtask

    task automatic test_start_busy;
        build_keys(fips_k0);
        load(rk[10]);
        consume(1'b0, 1'b1, 1'b0);
        checks++; if (obs0[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin errors++; $display("FAIL poke0 got %h", obs0[0]); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        build_keys(fips_k0);
        load(rk[10]);
        key_ready = 1'b1;
        while (kr0 !== 4'd6 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (kr0 !== 4'd6) begin errors++; $display("FAIL reach6 got %0d exp 6", kr0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({ko0, kr0, kv0, b0, d0} !== '0) begin errors++; $display("FAIL async reset got %h/%0d/%b/%b/%b exp 0", ko0, kr0, kv0, b0, d0); end
        checks++; if ({ko1, kr1, kv1, b1, d1} !== '0) begin errors++; $display("FAIL async reset_eq got %h exp 0", ko1); end
        key_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (d0 !== 1'b0 || kv0 !== 1'b0) begin errors++; $display("FAIL post reset got d%b v%b exp 0", d0, kv0); end
        end
        rst_n = 1'b1;
        load(rk[10]);
        consume(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        build_keys(fips_k0);
        load(rk[10]);
        consume(1'b0, 1'b0, 1'b1);
        consume(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            build_keys({$urandom, $urandom, $urandom, $urandom});
            load(rk[10]);
            consume(1'b1, i == 2, i == 1);
            if (i == 1) consume(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_idle_ready();
        test_fips();
        test_eq_inv();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
